// File: rtl/mvu_jobctl.sv
// Job sequencer for the MVU address generators: accepts a job, clears the AGU, issues
// cfg_cycles enables, drains the pipeline, reports done. Optional perf counters: MVU_JOBCTL_PERF_EN.
module mvu_jobctl #(
    parameter int BPREC = 6,
    parameter int BCNT  = 24,
    parameter int BOCNT = 16,
    parameter int DRAIN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [BCNT-1:0]  cfg_cycles,
    input  logic [BPREC-1:0] cfg_iprec,
    input  logic [BPREC-1:0] cfg_wprec,
    input  logic             abort,
    input  logic             stall,
    input  logic             acc_done,
    output logic             agu_clr,
    output logic             agu_en,
    output logic [BPREC-1:0] iprecision,
    output logic [BPREC-1:0] wprecision,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [BOCNT-1:0] nacc
`ifdef MVU_JOBCTL_PERF_EN
    ,
    output logic [BCNT-1:0]  stall_cnt,
    output logic [BCNT-1:0]  run_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN - 1);

    state_t          state;
    logic [BCNT-1:0] remaining;
    logic [3:0]      drain_cnt;
    logic            run;
    logic            step;
    logic            accept;

    // The only combinational output path: stall gates the registered run flag.
    assign step   = run & ~stall;
    assign agu_en = step;
    assign accept = start & ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ready      <= 1'b1;
            busy       <= 1'b0;
            agu_clr    <= 1'b0;
            run        <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            remaining  <= '0;
            drain_cnt  <= '0;
            iprecision <= '0;
            wprecision <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        iprecision <= cfg_iprec;
                        wprecision <= cfg_wprec;
                        remaining  <= cfg_cycles;
                        aborted    <= 1'b0;
                        ready      <= 1'b0;
                        busy       <= 1'b1;
                        agu_clr    <= 1'b1;
                        state      <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    agu_clr <= 1'b0;
                    if (abort || remaining == '0) begin
                        aborted   <= abort;
                        drain_cnt <= DRAIN_LOAD;
                        state     <= S_DRAIN;
                    end else begin
                        run   <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (step) begin
                        remaining <= remaining - BCNT'(1);
                    end
                    // An abort coinciding with the last step still lets that step out.
                    if (abort || (step && remaining == BCNT'(1))) begin
                        if (abort) begin
                            aborted <= 1'b1;
                        end
                        run       <= 1'b0;
                        drain_cnt <= DRAIN_LOAD;
                        state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end
                    if (drain_cnt == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    agu_clr <= 1'b0;
                    run     <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nacc <= '0;
        end else if (accept) begin
            nacc <= '0;
        end else if (busy && acc_done && nacc != '1) begin
            nacc <= nacc + BOCNT'(1);
        end
    end

`ifdef MVU_JOBCTL_PERF_EN
    // run_cnt starts at 1 so the accept cycle itself is included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            run_cnt   <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
            run_cnt   <= BCNT'(1);
        end else begin
            if (run && stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + BCNT'(1);
            end
            if (busy && run_cnt != '1) begin
                run_cnt <= run_cnt + BCNT'(1);
            end
        end
    end
`endif

endmodule
